dmi_uart_host_bridge: RTL and testbench

- Host-side counterpart of the DMI UART TAP.
- Turns parallel DMI-TAP requests (command, address, data) into the TAP's received-byte stream: command byte with command flag, then data bytes.
- Collects the TAP's transmitted response bytes back into WIDTH-bit words.
- Used as the loop-back peer in system benches and as the on-chip host bridge when the UART PHY is bypassed.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_word_assembler.sv | 38 +++
 rtl/dmi_uart_host_bridge.sv | 96 +++++++++
 tb/tb_dmi_uart_host_bridge.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared DMI UART codes, bridge state type and byte-count helper
package uart_pkg;
  localparam int IRLENGTH = 5;
  localparam int CMDLEN = 8 - IRLENGTH;
  localparam logic [CMDLEN-1:0] CMD_NOP = 3'd0;
  localparam logic [CMDLEN-1:0] CMD_WRITE = 3'd1;
  localparam logic [CMDLEN-1:0] CMD_READ = 3'd2;
  localparam logic [CMDLEN-1:0] CMD_CONT_READ = 3'd3;
  localparam logic [CMDLEN-1:0] CMD_RESET = 3'd4;
  localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
  localparam logic [IRLENGTH-1:0] ADDR_DTMCS = 5'h10;
  localparam logic [IRLENGTH-1:0] ADDR_DMI = 5'h11;
  localparam logic [IRLENGTH-1:0] ADDR_BYPASS = 5'h1f;
  typedef enum logic [2:0] {IDLE, SEND_CMD, SEND_DATA, RECV, CONT} bridge_state_t;
  function automatic int nbytes(input int width);
    return (width + 7) / 8;
  endfunction
endpackage

// File: rtl/uart_word_assembler.sv
// uart_word_assembler: shifts TAP bytes in LSB first and emits a WIDTH-bit word
//   clk, rst        clock, async active-high reset
//   push, byte_in   take one byte
//   clear           drop the partial word (a completing push still wins)
//   done            this push completes a word
//   word_valid/word one-cycle pulse with the completed word, word held
module uart_word_assembler #(
  parameter int WIDTH = 41,
  parameter int NBYTES = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             clear,
  input  logic [7:0]       byte_in,
  output logic             done,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
);
  localparam int CW = $clog2(NBYTES) + 1;
  logic [NBYTES*8-1:0] shreg, full;
  logic [CW-1:0] cnt;
  assign done = push && cnt == CW'(NBYTES - 1);
  assign full = (NBYTES*8)'({byte_in, shreg} >> 8);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= done;
      if (push) shreg <= full;
      if (done) word <= full[WIDTH-1:0];
      cnt <= (done || clear) ? '0 : push ? cnt + 1'b1 : cnt;
    end
  end
endmodule

// File: rtl/dmi_uart_host_bridge.sv
// dmi_uart_host_bridge: host-side peer of the DMI UART TAP
//   REQ_*            parallel request in (command, address, write data)
//   RSP_*            assembled response word, RSP_VALID_O one-cycle pulse
//   DATA_REC_O/RX_EMPTY_O/CMD_REC_O/READ_I   byte stream presented to the TAP
//   TX_READY_O/WRITE_I/DATA_SEND_I           bytes pushed back by the TAP
//   SEND_COMMAND_I/COMMAND_I/CMD_EVT_O/CMD_BYTE_O  TAP command bytes
module dmi_uart_host_bridge
  import uart_pkg::*;
#(
  parameter int WIDTH = 41,
  localparam int NBYTES = nbytes(WIDTH)
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                REQ_VALID_I,
  output logic                REQ_READY_O,
  input  logic [7-IRLENGTH:0] REQ_CMD_I,
  input  logic [IRLENGTH-1:0] REQ_ADDR_I,
  input  logic [WIDTH-1:0]    REQ_DATA_I,
  output logic                RSP_VALID_O,
  output logic [WIDTH-1:0]    RSP_DATA_O,
  output logic [7:0]          DATA_REC_O,
  output logic                RX_EMPTY_O,
  output logic                CMD_REC_O,
  input  logic                READ_I,
  output logic                TX_READY_O,
  input  logic                WRITE_I,
  input  logic [7:0]          DATA_SEND_I,
  input  logic                SEND_COMMAND_I,
  input  logic [7:0]          COMMAND_I,
  output logic                CMD_EVT_O,
  output logic [7:0]          CMD_BYTE_O
);
  localparam int IW = $clog2(NBYTES) + 1;
  bridge_state_t state, state_nxt;
  // outgoing bytes: command byte at the bottom, padded payload above it
  logic [NBYTES*8+7:0] obuf;
  logic [NBYTES*8-1:0] wpad;
  logic [IW-1:0] idx;
  logic accept, pop, take, push, cmd_take, clear, done;
  assign wpad = (NBYTES*8)'(REQ_DATA_I);
  assign accept = REQ_VALID_I & REQ_READY_O;
  assign pop = READ_I & ~RX_EMPTY_O;
  assign TX_READY_O = (state == RECV) || (state == CONT);
  assign take = WRITE_I & TX_READY_O;
  assign push = take & ~SEND_COMMAND_I;
  assign cmd_take = take & SEND_COMMAND_I;
  assign clear = cmd_take | (state == CONT && accept);
  assign DATA_REC_O = obuf[7:0];
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? SEND_CMD : IDLE;
      SEND_CMD: state_nxt = !pop ? SEND_CMD :
                            obuf[7:IRLENGTH] == CMD_WRITE ? SEND_DATA :
                            obuf[7:IRLENGTH] == CMD_READ ? RECV :
                            obuf[7:IRLENGTH] == CMD_CONT_READ ? CONT : IDLE;
      SEND_DATA: state_nxt = (pop && idx == IW'(NBYTES - 1)) ? IDLE : SEND_DATA;
      RECV: state_nxt = done ? IDLE : RECV;
      CONT: state_nxt = accept ? SEND_CMD : CONT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state <= IDLE;
      obuf <= '0;
      idx <= '0;
      REQ_READY_O <= 1'b0;
      RX_EMPTY_O <= 1'b1;
      CMD_REC_O <= 1'b0;
      CMD_EVT_O <= 1'b0;
      CMD_BYTE_O <= '0;
    end else begin
      state <= state_nxt;
      REQ_READY_O <= state_nxt == IDLE || state_nxt == CONT;
      RX_EMPTY_O <= !(state_nxt == SEND_CMD || state_nxt == SEND_DATA);
      CMD_REC_O <= state_nxt == SEND_CMD;
      obuf <= accept ? {wpad, REQ_CMD_I, REQ_ADDR_I} :
              pop ? (state_nxt == SEND_DATA ? obuf >> 8 : '0) : obuf;
      idx <= accept ? '0 : (pop && state == SEND_DATA) ? idx + 1'b1 : idx;
      CMD_EVT_O <= cmd_take;
      if (cmd_take) CMD_BYTE_O <= COMMAND_I;
    end
  end
  uart_word_assembler #(.WIDTH(WIDTH), .NBYTES(NBYTES)) u_asm (
    .clk(CLK_I),
    .rst(RST_I),
    .push(push),
    .clear(clear),
    .byte_in(DATA_SEND_I),
    .done(done),
    .word_valid(RSP_VALID_O),
    .word(RSP_DATA_O)
  );
endmodule

// File: tb/tb_dmi_uart_host_bridge.sv
// tb_dmi_uart_host_bridge: randomized bench against a queue-based model of the bridge
module tb_dmi_uart_host_bridge;
  import uart_pkg::*;
  localparam int WIDTH = 41;
  localparam int NB = nbytes(WIDTH);
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0;
  logic [7-IRLENGTH:0] req_cmd = '0;
  logic [IRLENGTH-1:0] req_addr = '0;
  logic [WIDTH-1:0] req_data = '0;
  logic rd = 1'b0, wr = 1'b0, send_cmd = 1'b0;
  logic [7:0] data_send = '0, command = '0;
  logic req_ready, rsp_valid, rx_empty, cmd_rec, tx_ready, cmd_evt;
  logic [WIDTH-1:0] rsp_data;
  logic [7:0] data_rec, cmd_byte;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  dmi_uart_host_bridge #(.WIDTH(WIDTH)) dut (
    .CLK_I(clk), .RST_I(rst),
    .REQ_VALID_I(req_valid), .REQ_READY_O(req_ready),
    .REQ_CMD_I(req_cmd), .REQ_ADDR_I(req_addr), .REQ_DATA_I(req_data),
    .RSP_VALID_O(rsp_valid), .RSP_DATA_O(rsp_data),
    .DATA_REC_O(data_rec), .RX_EMPTY_O(rx_empty), .CMD_REC_O(cmd_rec), .READ_I(rd),
    .TX_READY_O(tx_ready), .WRITE_I(wr), .DATA_SEND_I(data_send),
    .SEND_COMMAND_I(send_cmd), .COMMAND_I(command),
    .CMD_EVT_O(cmd_evt), .CMD_BYTE_O(cmd_byte)
  );
  typedef enum {M_IDLE, M_BUSY, M_RECV, M_CONT} mode_t;
  mode_t mode = M_IDLE, pend = M_IDLE;
  int q[$];
  logic [7:0] rxb[$];
  logic [8:0] pq[$];
  logic [7:0] seen[$];
  logic [WIDTH-1:0] rsp_log[$];
  logic [WIDTH-1:0] e_rsp = '0;
  logic [7:0] e_cmdb = '0, cur_byte = '0;
  bit fresh = 1'b1, e_valid = 1'b0, e_evt = 1'b0;
  bit acc_now, pop_now, take_now, have;
  int rd_mode = 0, evts = 0, cyc = 0;
  bit wr_rand = 1'b0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic bit e_ready();
    return !fresh && (mode == M_IDLE || mode == M_CONT);
  endfunction
  function automatic bit e_txr();
    return mode == M_RECV || mode == M_CONT;
  endfunction
  function automatic void m_reset();
    q.delete();
    rxb.delete();
    mode = M_IDLE;
    fresh = 1'b1;
    e_rsp = '0;
    e_valid = 1'b0;
    e_evt = 1'b0;
    e_cmdb = '0;
  endfunction
  function automatic void m_edge();
    logic [63:0] w, d;
    acc_now = req_valid && e_ready();
    pop_now = rd && q.size() > 0;
    take_now = wr && e_txr();
    e_valid = 1'b0;
    e_evt = 1'b0;
    if (take_now && send_cmd) begin
      e_cmdb = command;
      e_evt = 1'b1;
      rxb.delete();
    end else if (take_now) begin
      rxb.push_back(data_send);
      if (rxb.size() == NB) begin
        w = 0;
        foreach (rxb[i]) w |= 64'(rxb[i]) << (8 * i);
        e_rsp = w[WIDTH-1:0];
        e_valid = 1'b1;
        rxb.delete();
        if (mode == M_RECV) mode = M_IDLE;
      end
    end
    if (acc_now && mode == M_CONT) rxb.delete();
    if (pop_now) begin
      seen.push_back(cur_byte);
      void'(q.pop_front());
      if (q.size() == 0) mode = pend;
    end
    if (acc_now) begin
      q.push_back(256 | int'({req_cmd, req_addr}));
      if (req_cmd == CMD_WRITE) begin
        d = 64'(req_data);
        for (int i = 0; i < NB; i++) q.push_back(int'((d >> (8 * i)) & 64'hff));
      end
      pend = req_cmd == CMD_READ ? M_RECV : req_cmd == CMD_CONT_READ ? M_CONT : M_IDLE;
      mode = M_BUSY;
    end
    fresh = 1'b0;
  endfunction
  task automatic cmp_all();
    chk("req_ready", req_ready, e_ready());
    chk("rx_empty", rx_empty, q.size() == 0);
    if (q.size() > 0) begin
      chk("data_rec", data_rec, q[0] & 255);
      chk("cmd_rec", cmd_rec, q[0] >> 8);
    end
    chk("tx_ready", tx_ready, e_txr());
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_data", rsp_data, e_rsp);
    chk("cmd_evt", cmd_evt, e_evt);
    chk("cmd_byte", cmd_byte, e_cmdb);
    if (rsp_valid) rsp_log.push_back(rsp_data);
    if (cmd_evt) evts++;
    cur_byte = data_rec;
  endtask
  task automatic step();
    logic [8:0] it;
    rd = rd_mode == 1 || (rd_mode == 2 && cyc % 2 == 1) || (rd_mode == 3 && $urandom % 2 == 1);
    have = pq.size() > 0 && (!wr_rand || $urandom % 3 != 0);
    it = have ? pq[0] : 9'($urandom);
    wr = have;
    send_cmd = have ? it[8] : 1'($urandom);
    command = it[8] ? it[7:0] : 8'($urandom);
    data_send = it[8] ? 8'($urandom) : it[7:0];
    @(posedge clk);
    cyc++;
    if (rst) m_reset();
    else begin
      m_edge();
      if (take_now && have) void'(pq.pop_front());
    end
    #1;
    cmp_all();
  endtask
  task automatic send_req(input logic [7-IRLENGTH:0] c, input logic [IRLENGTH-1:0] a, input logic [WIDTH-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_cmd = c;
    req_addr = a;
    req_data = d;
    do begin
      step();
      n++;
    end while (!acc_now && n < 50);
    chk("req_timeout", 64'(!acc_now), 0);
    req_valid = 1'b0;
    req_data = WIDTH'({$urandom, $urandom});
  endtask
  task automatic run_idle(input int max);
    int n = 0;
    while ((q.size() != 0 || mode != M_IDLE) && n < max) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n >= max), 0);
  endtask
  task automatic run_pushes(input int max);
    int n = 0;
    while (pq.size() != 0 && n < max) begin
      step();
      n++;
    end
    chk("push_timeout", 64'(n >= max), 0);
  endtask
  logic [7:0] t1_exp [7] = '{8'h21, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  initial begin
    int n;
    m_reset();
    step();
    step();
    rst = 1'b0;
    step();
    // write with pops every second cycle
    rd_mode = 2;
    seen.delete();
    send_req(CMD_WRITE, ADDR_IDCODE, 41'h1_2345_6789_AB);
    run_idle(100);
    chk("t1_count", seen.size(), 7);
    foreach (t1_exp[i]) chk("t1_byte", seen[i], t1_exp[i]);
    // single read
    rd_mode = 1;
    rsp_log.delete();
    pq = '{9'h0EF, 9'h0BE, 9'h0AD, 9'h0DE, 9'h000, 9'h000};
    send_req(CMD_READ, ADDR_IDCODE, '0);
    run_idle(100);
    chk("t2_pulses", rsp_log.size(), 1);
    chk("t2_rsp", rsp_data, 41'h0_DEAD_BEEF);
    chk("t2_txr", tx_ready, 0);
    // continuous read, two words
    rsp_log.delete();
    pq.delete();
    for (int i = 1; i <= 12; i++) pq.push_back(9'(i));
    send_req(CMD_CONT_READ, ADDR_DMI, '0);
    run_pushes(100);
    repeat (3) step();
    chk("t3_pulses", rsp_log.size(), 2);
    chk("t3_word0", rsp_log[0], 41'h0_0605_0403_0201);
    chk("t3_word1", rsp_log[1], 41'h0_0C0B_0A09_0807);
    chk("t3_txr", tx_ready, 1);
    // continuous read interrupted by a new request
    rsp_log.delete();
    pq = '{9'h031, 9'h032, 9'h033};
    run_pushes(50);
    send_req(CMD_RESET, ADDR_IDCODE, '0);
    chk("t4_cmd", data_rec, {CMD_RESET, ADDR_IDCODE});
    chk("t4_cmdrec", cmd_rec, 1);
    run_idle(50);
    chk("t4_pulses", rsp_log.size(), 0);
    // TAP command byte in the middle of a word
    rsp_log.delete();
    evts = 0;
    pq = '{9'h041, 9'h042, 9'h1A5, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015, 9'h017};
    send_req(CMD_READ, ADDR_DTMCS, '0);
    run_idle(100);
    chk("t5_evts", evts, 1);
    chk("t5_cmdbyte", cmd_byte, 8'hA5);
    chk("t5_pulses", rsp_log.size(), 1);
    chk("t5_word", rsp_log[0], 41'h115_1413_1211);
    // asynchronous reset after three data pops
    rd_mode = 2;
    seen.delete();
    send_req(CMD_WRITE, ADDR_DMI, WIDTH'({$urandom, $urandom}));
    n = 0;
    while (seen.size() < 4 && n < 50) begin
      step();
      n++;
    end
    chk("t6_pop_timeout", 64'(n >= 50), 0);
    #2 rst = 1'b1;
    #1;
    m_reset();
    cmp_all();
    step();
    rst = 1'b0;
    rd_mode = 1;
    seen.delete();
    send_req(CMD_WRITE, ADDR_DTMCS, WIDTH'({$urandom, $urandom}));
    run_idle(100);
    chk("t6_bytes", seen.size(), 7);
    // randomized traffic
    rd_mode = 3;
    wr_rand = 1'b1;
    for (int t = 0; t < 60; t++) begin
      int k;
      logic [7-IRLENGTH:0] c;
      pq.delete();
      repeat ($urandom_range(6, 14)) pq.push_back({1'($urandom % 10 == 0), 8'($urandom)});
      k = $urandom_range(0, 5);
      c = k < 2 ? CMD_WRITE : k == 2 ? CMD_READ : k == 3 ? CMD_CONT_READ : k == 4 ? CMD_NOP : CMD_RESET;
      send_req(c, IRLENGTH'($urandom), WIDTH'({$urandom, $urandom}));
      repeat ($urandom_range(5, 40)) step();
      n = 0;
      while (mode != M_IDLE && mode != M_CONT && n < 300) begin
        if (pq.size() == 0) pq.push_back({1'b0, 8'($urandom)});
        step();
        n++;
      end
      chk("drain_timeout", 64'(n >= 300), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
